// File: rtl/fifo_arb_pkg.sv
// Shared types and the rotating-priority search used by the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } fifo_arb_state_t;

  localparam int unsigned STATS_W = 16;
  localparam int unsigned MAX_REQ = 16;

  // The search wraps modulo MAX_REQ. Valid bits at or above NUM_REQ are zero,
  // so the result matches a search that wraps modulo NUM_REQ.
  function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [3:0]         last);
    logic [3:0] idx;
    for (int unsigned i = 1; i <= MAX_REQ; i++) begin
      idx = last + 4'(i);
      if (valid[idx]) return idx;
    end
    return last;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr.sv
// Combinational picker: first valid requester after last_owner, wrapping round.
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         valid,
  input  logic [$clog2(NUM_REQ)-1:0] last_owner,
  output logic [$clog2(NUM_REQ)-1:0] index,
  output logic                       any_valid
);

  localparam int unsigned OW = $clog2(NUM_REQ);

  logic [MAX_REQ-1:0] valid_ext;
  logic [3:0]         pick;

  always_comb begin
    valid_ext = '0;
    valid_ext[NUM_REQ-1:0] = valid;
  end

  assign pick      = rr_pick(valid_ext, 4'(last_owner));
  assign index     = OW'(pick);
  assign any_valid = |valid;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ valid/ready producers.
// Optional per-requester accept counters: define FIFO_WR_ARBITER_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned DWIDTH    = 32,
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                        clk_i,
  input  logic                        srst_i,
  input  logic [NUM_REQ*DWIDTH-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  output logic [DWIDTH-1:0]           fifo_data_o,
  output logic                        fifo_wrreq_o,
  input  logic                        fifo_full_i,
  output logic [NUM_REQ-1:0]          grant_o,
  output logic                        busy_o
`ifdef FIFO_WR_ARBITER_STATS_EN
  ,
  input  logic                        stats_clr_i,
  output logic [NUM_REQ*STATS_W-1:0]  stats_cnt_o
`endif
);

  localparam int unsigned OW = $clog2(NUM_REQ);
  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  fifo_arb_state_t state, state_n;
  logic [OW-1:0]   owner, owner_n, last_owner, last_owner_n;
  logic [BW-1:0]   burst_cnt, burst_cnt_n;
  logic [OW-1:0]   pick_idx;
  logic            any_valid;
  logic            owner_valid;
  logic [DWIDTH-1:0] slice [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_slice
    assign slice[k] = req_data_i[k*DWIDTH +: DWIDTH];
  end

  assign owner_valid = req_valid_i[owner];
  assign fifo_data_o = slice[owner];

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .valid      (req_valid_i),
    .last_owner (last_owner),
    .index      (pick_idx),
    .any_valid  (any_valid)
  );

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= OW'(NUM_REQ - 1);
      burst_cnt  <= '0;
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      last_owner <= last_owner_n;
      burst_cnt  <= burst_cnt_n;
    end
  end

  always_comb begin
    state_n      = state;
    owner_n      = owner;
    last_owner_n = last_owner;
    burst_cnt_n  = burst_cnt;
    req_ready_o  = '0;
    fifo_wrreq_o = 1'b0;
    grant_o      = '0;
    busy_o       = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_valid) begin
          owner_n     = pick_idx;
          burst_cnt_n = '0;
          state_n     = GRANT;
        end
      end
      GRANT: begin
        busy_o              = 1'b1;
        grant_o[owner]      = 1'b1;
        req_ready_o[owner]  = !fifo_full_i;
        fifo_wrreq_o        = owner_valid && !fifo_full_i;
        if (fifo_wrreq_o) burst_cnt_n = burst_cnt + 1'b1;
        // A full FIFO freezes the burst without releasing; only a dropped
        // valid or the last word of the burst hands the port back.
        if (!owner_valid || (fifo_wrreq_o && burst_cnt == BW'(MAX_BURST - 1))) begin
          state_n      = IDLE;
          last_owner_n = owner;
          burst_cnt_n  = '0;
        end
      end
      default: state_n = IDLE;
    endcase
    if (srst_i) begin
      req_ready_o  = '0;
      fifo_wrreq_o = 1'b0;
      grant_o      = '0;
      busy_o       = 1'b0;
    end
  end

`ifdef FIFO_WR_ARBITER_STATS_EN
  logic [STATS_W-1:0] stats_q [NUM_REQ];

  always_ff @(posedge clk_i) begin
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (srst_i || stats_clr_i) begin
        stats_q[k] <= '0;
      end else if (fifo_wrreq_o && owner == OW'(k) && stats_q[k] != '1) begin
        stats_q[k] <= stats_q[k] + 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_stats
    assign stats_cnt_o[k*STATS_W +: STATS_W] = stats_q[k];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomised and directed bench for fifo_wr_arbiter with a queue-based FIFO and rule-level model.
module tb_fifo_wr_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned NR = 4;
  localparam int unsigned MB = 8;
  localparam int unsigned FDEPTH = 16;

  logic               clk_i = 1'b0;
  logic               srst_i;
  logic [NR*DW-1:0]   req_data_i;
  logic [NR-1:0]      req_valid_i;
  logic [NR-1:0]      req_ready_o;
  logic [DW-1:0]      fifo_data_o;
  logic               fifo_wrreq_o;
  logic               fifo_full_i;
  logic [NR-1:0]      grant_o;
  logic               busy_o;
`ifdef FIFO_WR_ARBITER_STATS_EN
  logic               stats_clr_i;
  logic [NR*16-1:0]   stats_cnt_o;
`endif

  fifo_wr_arbiter #(.DWIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
    .clk_i        (clk_i),
    .srst_i       (srst_i),
    .req_data_i   (req_data_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .fifo_data_o  (fifo_data_o),
    .fifo_wrreq_o (fifo_wrreq_o),
    .fifo_full_i  (fifo_full_i),
    .grant_o      (grant_o),
    .busy_o       (busy_o)
`ifdef FIFO_WR_ARBITER_STATS_EN
    ,
    .stats_clr_i  (stats_clr_i),
    .stats_cnt_o  (stats_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int unsigned checks = 0;
  int unsigned failures = 0;

  // Reference state: who holds the port, how many words in this grant, who held it last.
  bit          m_busy;
  int unsigned m_owner, m_last, m_cnt;
  int unsigned seq [NR];
  int unsigned acc0;

  logic [DW-1:0] fq [$];
  int unsigned   og [$];
  int unsigned   gw [$];
  int unsigned   gw_cur;
  logic [NR-1:0] prev_grant;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned onehot_idx(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return 0;
  endfunction

  // One clock cycle: drive, check outputs against the model, update FIFO and model.
  task automatic step(input logic rst, input logic [NR-1:0] vld, input logic rd);
    logic          full, e_wr, e_busy, rel;
    logic [NR-1:0] e_grant, e_rdy;
    srst_i      = rst;
    req_valid_i = vld;
    for (int k = 0; k < NR; k++) req_data_i[k*DW +: DW] = {8'(k), 24'(seq[k])};
    full        = (fq.size() >= FDEPTH);
    fifo_full_i = full;
    #3;
    e_grant = '0; e_rdy = '0; e_wr = 1'b0; e_busy = 1'b0;
    if (!rst && m_busy) begin
      e_grant[m_owner] = 1'b1;
      e_busy = 1'b1;
      if (!full) e_rdy = e_grant;
      e_wr = vld[m_owner] && !full;
    end
    check_eq("grant", 64'(grant_o), 64'(e_grant));
    check_eq("busy", 64'(busy_o), 64'(e_busy));
    check_eq("ready", 64'(req_ready_o), 64'(e_rdy));
    check_eq("wrreq", 64'(fifo_wrreq_o), 64'(e_wr));
    if (e_wr) check_eq("data", 64'(fifo_data_o), 64'({8'(m_owner), 24'(seq[m_owner])}));

    // Environment: a plain FIFO fed by whatever the DUT writes.
    if (rd && fq.size() > 0) void'(fq.pop_front());
    if (fifo_wrreq_o) fq.push_back(fifo_data_o);
    if (grant_o != '0 && prev_grant == '0) begin
      og.push_back(onehot_idx(grant_o));
      gw_cur = 0;
    end
    if (fifo_wrreq_o) gw_cur++;
    prev_grant = grant_o;

    if (rst) begin
      m_busy = 0; m_owner = 0; m_last = NR - 1; m_cnt = 0;
    end else if (!m_busy) begin
      for (int i = 1; i <= NR; i++) begin
        if (vld[(m_last + i) % NR]) begin
          m_owner = (m_last + i) % NR;
          m_busy  = 1;
          m_cnt   = 0;
          break;
        end
      end
    end else begin
      rel = !vld[m_owner] || (e_wr && m_cnt == MB - 1);
      if (e_wr) begin
        seq[m_owner]++;
        m_cnt++;
        if (m_owner == 0) acc0++;
      end
      if (rel) begin
        m_busy = 0;
        m_last = m_owner;
        gw.push_back(gw_cur);
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, '0, 1'b0);
    fq.delete(); og.delete(); gw.delete();
    prev_grant = '0;
    for (int k = 0; k < NR; k++) seq[k] = 0;
  endtask

  initial begin
    srst_i = 1'b1; req_valid_i = '0; req_data_i = '0; fifo_full_i = 1'b0;
`ifdef FIFO_WR_ARBITER_STATS_EN
    stats_clr_i = 1'b0;
`endif
    m_busy = 0; m_owner = 0; m_last = NR - 1; m_cnt = 0; acc0 = 0; gw_cur = 0;
    prev_grant = '0;
    for (int k = 0; k < NR; k++) seq[k] = 0;
    @(posedge clk_i);
    #1;

    // Requester 2 streams three words into an empty FIFO.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 4'b0100, 1'b0);
    step(1'b0, 4'b0000, 1'b0);
    check_eq("stream_used", 64'(fq.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      if (fq.size() > i) check_eq("stream_q", 64'(fq[i]), 64'({8'd2, 24'(i)}));

    // All requesters continuously valid: round-robin with full bursts.
    do_reset();
    for (int i = 0; i < 4 * (MB + 1) + 2; i++) step(1'b0, 4'b1111, 1'b1);
    check_eq("rr_grants", 64'(og.size()), 64'd5);
    for (int i = 0; i < 5; i++)
      if (og.size() > i) check_eq("rr_order", 64'(og[i]), 64'(i % NR));
    for (int i = 0; i < 4; i++)
      if (gw.size() > i) check_eq("rr_burst", 64'(gw[i]), 64'(MB));

    // FIFO fills mid-grant: stall with grant held, then resume one word per freed slot.
    do_reset();
    for (int i = 0; i < FDEPTH - 2; i++) fq.push_back('0);
    for (int i = 0; i < 6; i++) step(1'b0, 4'b0001, 1'b0);
    check_eq("full_hold", 64'(grant_o), 64'(4'b0001));
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 4'b0001, 1'b1);
      step(1'b0, 4'b0001, 1'b0);
    end
    check_eq("full_bursts", 64'(gw.size() > 0 ? gw[0] : 0), 64'(MB));

    // Requester 1 withdraws after two words; requester 3 wins the next round.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0010, 1'b1);
    step(1'b0, 4'b0000, 1'b1);
    step(1'b0, 4'b1010, 1'b1);
    check_eq("rr_after_drop", 64'(grant_o), 64'(4'b1000));

    // Reset in the middle of a burst.
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b0, 4'b0001, 1'b1);
    step(1'b1, 4'b0001, 1'b1);
    step(1'b0, 4'b0000, 1'b1);
    step(1'b0, 4'b1111, 1'b1);
    check_eq("rst_last_owner", 64'(grant_o), 64'(4'b0001));

`ifdef FIFO_WR_ARBITER_STATS_EN
    do_reset();
    acc0 = 0;
    for (int i = 0; i < 20; i++) step(1'b0, 4'b0001, 1'b1);
    check_eq("stats_cnt", 64'(stats_cnt_o[15:0]), 64'(acc0));
    stats_clr_i = 1'b1;
    step(1'b0, 4'b0001, 1'b1);
    stats_clr_i = 1'b0;
    check_eq("stats_clr", 64'(stats_cnt_o[15:0]), 64'd0);
`endif

    // Randomised traffic with occasional resets and FIFO back-pressure.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic [NR-1:0] v;
      for (int k = 0; k < NR; k++) v[k] = ($urandom_range(9) < 7);
      step($urandom_range(99) < 2, v, 1'($urandom_range(1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
